memory_unit: RTL and testbench

- Word-addressed unified instruction/data RAM that is the responder on the cpu memory interface (mem_address, mem_read, mem_write, mem_write_data → mem_read_data).
- Owns the run lifecycle: zeroes memory, accepts a program image over a valid/ready load stream, pulses execute, serves the cpu until halted, then streams memory contents out over a valid/ready dump port for checking.

---
 rtl/memory_unit_pkg.sv | 27 ++
 rtl/memory_unit_ram_array.sv | 25 ++
 rtl/memory_unit.sv | 133 +++++++++++++
 tb/tb_memory_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_unit_pkg.sv
// Shared types and sizes for the unified instruction/data memory unit.
// State encodings are exposed so a cpu bench can decode the debug output.
package memory_unit_pkg;

  localparam int WORD_SIZE     = 16;
  localparam int MEM_ADDR_SIZE = 8;
  localparam int DEPTH         = 2**MEM_ADDR_SIZE;

  typedef logic [MEM_ADDR_SIZE-1:0] addr_t;
  typedef logic [WORD_SIZE-1:0]     word_t;

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_DUMP  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  typedef struct packed {
    logic  en;
    addr_t addr;
    word_t data;
  } wr_req_t;

endpackage

// File: rtl/memory_unit_ram_array.sv
// DEPTH x WORD_SIZE storage: one synchronous write port,
// two asynchronous read ports (cpu and dump).
module memory_unit_ram_array
  import memory_unit_pkg::*;
(
  input  logic    clk_i,
  input  wr_req_t wr_i,
  input  addr_t   cpu_addr_i,
  output word_t   cpu_data_o,
  input  addr_t   dump_addr_i,
  output word_t   dump_data_o
);

  word_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_i.en) begin
      mem_q[wr_i.addr] <= wr_i.data;
    end
  end

  assign cpu_data_o  = mem_q[cpu_addr_i];
  assign dump_data_o = mem_q[dump_addr_i];

endmodule

// File: rtl/memory_unit.sv
// Run lifecycle controller: clear, program load, start pulse,
// cpu service until halt, then a valid/ready memory dump.
module memory_unit
  import memory_unit_pkg::*;
#(
  parameter int DUMP_WORDS = DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [MEM_ADDR_SIZE-1:0] mem_address,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic [WORD_SIZE-1:0]     mem_write_data,
  output logic [WORD_SIZE-1:0]     mem_read_data,
  input  logic                     halted,
  output logic                     execute,
  input  logic                     load_valid,
  input  logic [WORD_SIZE-1:0]     load_data,
  input  logic                     load_last,
  output logic                     load_ready,
  output logic                     dump_valid,
  output logic [MEM_ADDR_SIZE-1:0] dump_address,
  output logic [WORD_SIZE-1:0]     dump_data,
  input  logic                     dump_ready,
  output logic [2:0]               state
);

  localparam addr_t LAST_ADDR = addr_t'(DEPTH - 1);
  localparam addr_t LAST_DUMP = addr_t'(DUMP_WORDS - 1);

  state_e  state_q, state_d;
  addr_t   clear_ptr_q, clear_ptr_d;
  addr_t   load_ptr_q, load_ptr_d;
  addr_t   dump_ptr_q, dump_ptr_d;
  wr_req_t wr;
  logic    rd_en;
  word_t   cpu_rd;
  word_t   dump_rd;

  memory_unit_ram_array u_ram (
    .clk_i       (clock),
    .wr_i        (wr),
    .cpu_addr_i  (mem_address),
    .cpu_data_o  (cpu_rd),
    .dump_addr_i (dump_ptr_q),
    .dump_data_o (dump_rd)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      clear_ptr_q <= '0;
      load_ptr_q  <= '0;
      dump_ptr_q  <= '0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
      load_ptr_q  <= load_ptr_d;
      dump_ptr_q  <= dump_ptr_d;
    end
  end

  // Strobes are masked during reset so the reset cycle is quiet.
  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    load_ptr_d  = load_ptr_q;
    dump_ptr_d  = dump_ptr_q;
    wr          = '0;
    rd_en       = 1'b0;
    execute     = 1'b0;
    load_ready  = 1'b0;
    dump_valid  = 1'b0;
    if (!reset) begin
      unique case (state_q)
        ST_CLEAR: begin
          wr.en   = 1'b1;
          wr.addr = clear_ptr_q;
          if (clear_ptr_q == LAST_ADDR) begin
            state_d = ST_LOAD;
          end else begin
            clear_ptr_d = clear_ptr_q + addr_t'(1);
          end
        end
        ST_LOAD: begin
          load_ready = 1'b1;
          if (load_valid) begin
            wr.en   = 1'b1;
            wr.addr = load_ptr_q;
            wr.data = load_data;
            if (load_last || load_ptr_q == LAST_ADDR) begin
              state_d = ST_START;
            end else begin
              load_ptr_d = load_ptr_q + addr_t'(1);
            end
          end
        end
        ST_START: begin
          execute = 1'b1;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          rd_en   = mem_read;
          wr.en   = mem_write;
          wr.addr = mem_address;
          wr.data = mem_write_data;
          if (halted) begin
            state_d    = ST_DUMP;
            dump_ptr_d = '0;
          end
        end
        ST_DUMP: begin
          dump_valid = 1'b1;
          if (dump_ready) begin
            if (dump_ptr_q == LAST_DUMP) begin
              state_d = ST_DONE;
            end else begin
              dump_ptr_d = dump_ptr_q + addr_t'(1);
            end
          end
        end
        ST_DONE: ;
        default: state_d = ST_CLEAR;
      endcase
    end
  end

  assign mem_read_data = rd_en      ? cpu_rd     : '0;
  assign dump_address  = dump_valid ? dump_ptr_q : '0;
  assign dump_data     = dump_valid ? dump_rd    : '0;
  assign state         = state_q;

endmodule

// File: tb/tb_memory_unit.sv
// Directed lifecycle sequence with randomized traffic, checked
// against an array model of memory contents.
module tb_memory_unit;
  import memory_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  addr_t       mem_address;
  logic        mem_read;
  logic        mem_write;
  word_t       mem_write_data;
  word_t       mem_read_data;
  logic        halted;
  logic        execute;
  logic        load_valid;
  word_t       load_data;
  logic        load_last;
  logic        load_ready;
  logic        dump_valid;
  addr_t       dump_address;
  word_t       dump_data;
  logic        dump_ready;
  logic [2:0]  state;

  int    vectors = 0;
  int    miscompares = 0;
  word_t model [DEPTH];
  word_t prog [$];

  memory_unit dut (
    .clock          (clock),
    .reset          (reset),
    .mem_address    (mem_address),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .halted         (halted),
    .execute        (execute),
    .load_valid     (load_valid),
    .load_data      (load_data),
    .load_last      (load_last),
    .load_ready     (load_ready),
    .dump_valid     (dump_valid),
    .dump_address   (dump_address),
    .dump_data      (dump_data),
    .dump_ready     (dump_ready),
    .state          (state)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic rand_cpu();
    mem_read       = 1'b1;
    mem_write      = 1'($urandom_range(0, 1));
    mem_address    = addr_t'($urandom);
    mem_write_data = word_t'($urandom);
  endtask

  task automatic quiet_cpu();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    halted    = 1'b0;
  endtask

  task automatic do_reset();
    int n;
    reset      = 1'b1;
    load_valid = 1'b1;
    dump_ready = 1'b1;
    rand_cpu();
    #1 chk("rst_outputs",
           {execute, load_ready, dump_valid, dump_address,
            dump_data, mem_read_data}, 32'h0);
    cyc();
    reset = 1'b0;
    dump_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    n = 0;
    while (n < 300) begin
      if (load_ready !== 1'b0) break;
      n++;
      cyc();
    end
    load_valid = 1'b0;
    quiet_cpu();
    chk("clear_cycles", n, DEPTH);
    chk("load_entry", {state, load_ready}, {3'd1, 1'b1});
  endtask

  task automatic load_prog(input int n, input bit last,
                           input bit finish, input bit gap_all);
    for (int i = 0; i < n; i++) begin
      if (gap_all || $urandom_range(0, 3) == 0) begin
        load_valid = 1'b0;
        rand_cpu();
        #1 chk("load_idle", {load_ready, execute, mem_read_data},
               {1'b1, 1'b0, 16'h0});
        cyc();
      end
      load_valid = 1'b1;
      load_data  = prog[i];
      load_last  = last && (i == n - 1);
      rand_cpu();
      #1 chk("load_accept", {load_ready, execute, mem_read_data},
             {1'b1, 1'b0, 16'h0});
      model[i] = prog[i];
      cyc();
    end
    load_last = 1'b0;
    quiet_cpu();
    if (finish) begin
      load_valid = 1'b1;
      load_data  = word_t'($urandom);
      #1 chk("start_pulse", {state, execute, load_ready},
             {3'd2, 1'b1, 1'b0});
      cyc();
      #1 chk("run_entry", {state, execute, load_ready},
             {3'd3, 1'b0, 1'b0});
    end
    load_valid = 1'b0;
  endtask

  task automatic run_step(input string tag, input addr_t a,
                          input bit r, input bit w, input word_t d);
    word_t exp;
    mem_address    = a;
    mem_read       = r;
    mem_write      = w;
    mem_write_data = d;
    halted         = 1'b0;
    exp = r ? model[a] : 16'h0;
    #1 chk(tag, {state, execute, mem_read_data}, {3'd3, 1'b0, exp});
    cyc();
    if (w) model[a] = d;
    quiet_cpu();
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      run_step("run_rand", addr_t'($urandom_range(0, 63)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               word_t'($urandom));
    end
  endtask

  task automatic halt_step(input bit w, input addr_t a, input word_t d);
    halted         = 1'b1;
    mem_write      = w;
    mem_address    = a;
    mem_write_data = d;
    #1 chk("halt_cycle", {state, dump_valid}, {3'd3, 1'b0});
    cyc();
    if (w) model[a] = d;
    quiet_cpu();
  endtask

  task automatic dump_all(input int stall0);
    int ns;
    for (int i = 0; i < DEPTH; i++) begin
      ns = (i == 0) ? stall0 : int'($urandom_range(0, 2));
      for (int s = 0; s < ns; s++) begin
        dump_ready = 1'b0;
        rand_cpu();
        #1 chk("dump_hold",
               {dump_valid, dump_address, dump_data, mem_read_data},
               {1'b1, addr_t'(i), model[i], 16'h0});
        cyc();
      end
      dump_ready = 1'b1;
      rand_cpu();
      #1 chk("dump_word",
             {dump_valid, dump_address, dump_data, mem_read_data},
             {1'b1, addr_t'(i), model[i], 16'h0});
      cyc();
    end
    quiet_cpu();
    for (int k = 0; k < 3; k++) begin
      load_valid = 1'b1;
      #1 chk("done_idle",
             {state, dump_valid, execute, load_ready, dump_address},
             {3'd5, 1'b0, 1'b0, 1'b0, 8'h0});
      cyc();
    end
    load_valid = 1'b0;
    dump_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    mem_address = '0;
    mem_write_data = '0;
    load_data = '0;
    load_last = 1'b0;
    load_valid = 1'b0;
    dump_ready = 1'b0;
    quiet_cpu();
    @(negedge clock);
    cyc();

    // Pass 1: fixed three-word program with gaps between words.
    do_reset();
    prog = '{16'h1234, 16'hABCD, 16'h00FF};
    load_prog(3, 1'b1, 1'b1, 1'b1);
    run_step("rd_prog0", 8'h00, 1'b1, 1'b0, 16'h0);
    run_step("rd_prog2", 8'h02, 1'b1, 1'b0, 16'h0);
    run_step("wr_beef", 8'h10, 1'b0, 1'b1, 16'hBEEF);
    run_step("rd_beef", 8'h10, 1'b1, 1'b0, 16'h0);
    run_step("rd_off", 8'h10, 1'b0, 1'b0, 16'h0);
    run_step("rdwr_old", 8'h10, 1'b1, 1'b1, 16'h1111);
    run_step("rd_new", 8'h10, 1'b1, 1'b0, 16'h0);
    run_step("wr_rep0", 8'h30, 1'b0, 1'b1, 16'h0777);
    run_step("wr_rep1", 8'h30, 1'b1, 1'b1, 16'h0777);
    run_random(40);
    halt_step(1'b1, 8'h20, 16'h5555);
    dump_all(4);

    // Pass 2: reset aborts a partial load; memory must come back zeroed.
    do_reset();
    prog = {};
    for (int i = 0; i < 5; i++) prog.push_back(word_t'($urandom));
    load_prog(2, 1'b0, 1'b0, 1'b0);
    do_reset();
    load_prog(3, 1'b1, 1'b1, 1'b0);
    run_random(10);
    halt_step(1'b0, 8'h00, 16'h0);
    dump_all(1);

    // Pass 3: full-depth load with no last marker.
    do_reset();
    prog = {};
    for (int i = 0; i < DEPTH; i++) prog.push_back(word_t'($urandom));
    load_prog(DEPTH, 1'b0, 1'b1, 1'b0);
    run_random(30);
    halt_step(1'b1, 8'hFF, word_t'($urandom));
    dump_all(0);

    // Pass 4: reset while the cpu is running.
    do_reset();
    prog = '{16'hC0DE};
    load_prog(1, 1'b1, 1'b1, 1'b0);
    run_random(10);
    do_reset();
    prog = '{16'h0042};
    load_prog(1, 1'b1, 1'b1, 1'b0);
    halt_step(1'b0, 8'h00, 16'h0);
    dump_all(2);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
